// File: rtl/frigate_osc_supervisor.sv
// -----------------------------------------------------------------------------
// frigate_osc_supervisor
// Digital supervisor for NCH oscillator channels (RC, LSXO, HSXO). Each channel
// is sequenced OFF -> STARTUP -> CHECK -> RUN, with STANDBY and FAIL side states.
// After a programmable startup delay, the oscillator is checked for activity by
// counting synchronised rising edges in back-to-back windows of 2**WIN_W cycles.
//
// Ports
//   clk             always-on supervisor clock
//   reset           synchronous, active-high reset
//   ch_req          per-channel enable request (level)
//   ch_standby_req  per-channel standby request, only acted on in RUN
//   startup_cycles  per-channel startup delay, channel i at [i*CNT_W +: CNT_W]
//   osc_dout        raw oscillator outputs, asynchronous to clk
//   osc_ena         oscillator enable to the analog frontend
//   osc_standby     oscillator standby to the analog frontend
//   ch_ready        channel verified running
//   ch_fail         channel failed, held until ch_req drops
//   fail_irq        one-cycle pulse when any channel enters FAIL
// -----------------------------------------------------------------------------
module frigate_osc_supervisor #(
    parameter int NCH       = 4,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 8,
    parameter int MIN_EDGES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_standby_req,
    input  logic [NCH*CNT_W-1:0] startup_cycles,
    input  logic [NCH-1:0]       osc_dout,
    output logic [NCH-1:0]       osc_ena,
    output logic [NCH-1:0]       osc_standby,
    output logic [NCH-1:0]       ch_ready,
    output logic [NCH-1:0]       ch_fail,
    output logic                 fail_irq
);

    localparam int EC_W = $clog2(MIN_EDGES) + 1;
    localparam logic [EC_W:0]    MIN_EDGES_C = (EC_W + 1)'(MIN_EDGES);
    localparam logic [CNT_W-1:0] SU_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ONE     = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [EC_W-1:0]  EC_ONE      = {{(EC_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_STARTUP = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_STANDBY = 3'd4;
    localparam logic [2:0] ST_FAIL    = 3'd5;

    logic [NCH-1:0] fail_entry_s;
    logic           fail_irq_r;

    genvar g;
    generate
        for (g = 0; g < NCH; g = g + 1) begin : g_ch
            logic [2:0]       sync_r;
            logic             edge_s;
            logic [2:0]       state_r;
            logic [2:0]       state_nxt_s;
            logic [CNT_W-1:0] su_cnt_r;
            logic [CNT_W-1:0] su_cnt_nxt_s;
            logic [WIN_W-1:0] win_cnt_r;
            logic [WIN_W-1:0] win_cnt_nxt_s;
            logic [EC_W-1:0]  edge_cnt_r;
            logic [EC_W-1:0]  edge_cnt_nxt_s;
            logic [EC_W-1:0]  edge_inc_s;
            logic             win_end_s;
            logic             alive_s;
            logic             ena_r;
            logic             standby_r;
            logic             ready_r;
            logic             fail_r;

            // Two-flop synchroniser plus a third flop for rising-edge detection.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_r <= 3'b000;
                end else begin
                    sync_r <= {sync_r[1:0], osc_dout[g]};
                end
            end

            assign edge_s     = sync_r[1] & ~sync_r[2];
            assign win_end_s  = (win_cnt_r == {WIN_W{1'b1}});
            // Saturating edge count; the edge of the current cycle still counts
            // towards a window that ends in this cycle.
            assign edge_inc_s = (edge_s && (edge_cnt_r != {EC_W{1'b1}})) ?
                                (edge_cnt_r + EC_ONE) : edge_cnt_r;
            assign alive_s    = (({1'b0, edge_cnt_r} + {{EC_W{1'b0}}, edge_s}) >= MIN_EDGES_C);

            // Channel next-state and counter logic; a dropped request wins over everything.
            always_comb begin
                state_nxt_s    = state_r;
                su_cnt_nxt_s   = su_cnt_r;
                win_cnt_nxt_s  = win_cnt_r;
                edge_cnt_nxt_s = edge_cnt_r;
                if (!ch_req[g]) begin
                    state_nxt_s    = ST_OFF;
                    su_cnt_nxt_s   = {CNT_W{1'b0}};
                    win_cnt_nxt_s  = {WIN_W{1'b0}};
                    edge_cnt_nxt_s = {EC_W{1'b0}};
                end else begin
                    case (state_r)
                        ST_OFF: begin
                            state_nxt_s  = ST_STARTUP;
                            su_cnt_nxt_s = startup_cycles[g*CNT_W +: CNT_W];
                        end
                        ST_STARTUP: begin
                            if (su_cnt_r == {CNT_W{1'b0}}) begin
                                state_nxt_s    = ST_CHECK;
                                win_cnt_nxt_s  = {WIN_W{1'b0}};
                                edge_cnt_nxt_s = {EC_W{1'b0}};
                            end else begin
                                su_cnt_nxt_s = su_cnt_r - SU_ONE;
                            end
                        end
                        ST_CHECK, ST_RUN: begin
                            if (win_end_s) begin
                                win_cnt_nxt_s  = {WIN_W{1'b0}};
                                edge_cnt_nxt_s = {EC_W{1'b0}};
                                // A dead window fails even if standby is requested now.
                                if (!alive_s) begin
                                    state_nxt_s = ST_FAIL;
                                end else if ((state_r == ST_RUN) && ch_standby_req[g]) begin
                                    state_nxt_s = ST_STANDBY;
                                end else begin
                                    state_nxt_s = ST_RUN;
                                end
                            end else if ((state_r == ST_RUN) && ch_standby_req[g]) begin
                                state_nxt_s    = ST_STANDBY;
                                win_cnt_nxt_s  = {WIN_W{1'b0}};
                                edge_cnt_nxt_s = {EC_W{1'b0}};
                            end else begin
                                win_cnt_nxt_s  = win_cnt_r + WIN_ONE;
                                edge_cnt_nxt_s = edge_inc_s;
                            end
                        end
                        ST_STANDBY: begin
                            if (!ch_standby_req[g]) begin
                                state_nxt_s    = ST_CHECK;
                                win_cnt_nxt_s  = {WIN_W{1'b0}};
                                edge_cnt_nxt_s = {EC_W{1'b0}};
                            end else begin
                                state_nxt_s = ST_STANDBY;
                            end
                        end
                        ST_FAIL: begin
                            state_nxt_s = ST_FAIL;
                        end
                        default: begin
                            state_nxt_s    = ST_OFF;
                            su_cnt_nxt_s   = {CNT_W{1'b0}};
                            win_cnt_nxt_s  = {WIN_W{1'b0}};
                            edge_cnt_nxt_s = {EC_W{1'b0}};
                        end
                    endcase
                end
            end

            // State, counters and outputs decoded from the next state so they align with it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_r    <= ST_OFF;
                    su_cnt_r   <= {CNT_W{1'b0}};
                    win_cnt_r  <= {WIN_W{1'b0}};
                    edge_cnt_r <= {EC_W{1'b0}};
                    ena_r      <= 1'b0;
                    standby_r  <= 1'b0;
                    ready_r    <= 1'b0;
                    fail_r     <= 1'b0;
                end else begin
                    state_r    <= state_nxt_s;
                    su_cnt_r   <= su_cnt_nxt_s;
                    win_cnt_r  <= win_cnt_nxt_s;
                    edge_cnt_r <= edge_cnt_nxt_s;
                    case (state_nxt_s)
                        ST_STARTUP, ST_CHECK: begin
                            ena_r <= 1'b1; standby_r <= 1'b0; ready_r <= 1'b0; fail_r <= 1'b0;
                        end
                        ST_RUN: begin
                            ena_r <= 1'b1; standby_r <= 1'b0; ready_r <= 1'b1; fail_r <= 1'b0;
                        end
                        ST_STANDBY: begin
                            ena_r <= 1'b1; standby_r <= 1'b1; ready_r <= 1'b1; fail_r <= 1'b0;
                        end
                        ST_FAIL: begin
                            ena_r <= 1'b0; standby_r <= 1'b0; ready_r <= 1'b0; fail_r <= 1'b1;
                        end
                        default: begin
                            ena_r <= 1'b0; standby_r <= 1'b0; ready_r <= 1'b0; fail_r <= 1'b0;
                        end
                    endcase
                end
            end

            assign fail_entry_s[g] = (state_nxt_s == ST_FAIL) && (state_r != ST_FAIL);
            assign osc_ena[g]      = ena_r;
            assign osc_standby[g]  = standby_r;
            assign ch_ready[g]     = ready_r;
            assign ch_fail[g]      = fail_r;
        end
    endgenerate

    // Merge per-channel FAIL entries into one registered interrupt pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_irq_r <= 1'b0;
        end else begin
            fail_irq_r <= |fail_entry_s;
        end
    end

    assign fail_irq = fail_irq_r;

endmodule

// File: tb/tb_frigate_osc_supervisor.sv
// Testbench for frigate_osc_supervisor: directed latency/boundary scenarios
// followed by randomized traffic, all compared cycle by cycle against a
// behavioural model that works from time-indexed oscillator samples.
module tb_frigate_osc_supervisor;

    localparam int NCH       = 4;
    localparam int CNT_W     = 16;
    localparam int WIN_W     = 8;
    localparam int MIN_EDGES = 4;
    localparam int WIN_LEN   = 1 << WIN_W;

    localparam int P_OFF   = 0;
    localparam int P_START = 1;
    localparam int P_CHECK = 2;
    localparam int P_RUN   = 3;
    localparam int P_STBY  = 4;
    localparam int P_FAIL  = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       ch_req;
    logic [NCH-1:0]       ch_standby_req;
    logic [NCH*CNT_W-1:0] startup_cycles;
    logic [NCH-1:0]       osc_dout;
    logic [NCH-1:0]       osc_ena;
    logic [NCH-1:0]       osc_standby;
    logic [NCH-1:0]       ch_ready;
    logic [NCH-1:0]       ch_fail;
    logic                 fail_irq;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int m_phase [NCH];
    int m_stay  [NCH];
    int m_age   [NCH];
    int m_edges [NCH];
    bit m_log   [NCH][4];
    int m_cyc = 8;
    bit m_irq;

    // random oscillator generators
    int per [NCH];
    int pc  [NCH];

    always #5 clk = ~clk;

    frigate_osc_supervisor #(
        .NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .MIN_EDGES(MIN_EDGES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch_req(ch_req),
        .ch_standby_req(ch_standby_req),
        .startup_cycles(startup_cycles),
        .osc_dout(osc_dout),
        .osc_ena(osc_ena),
        .osc_standby(osc_standby),
        .ch_ready(ch_ready),
        .ch_fail(ch_fail),
        .fail_irq(fail_irq)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {15'd0, osc_ena, osc_standby, ch_ready, ch_fail, fail_irq};
    endfunction

    function automatic logic [31:0] model_outs();
        logic [NCH-1:0] e, s, r, f;
        for (int ch = 0; ch < NCH; ch++) begin
            e[ch] = (m_phase[ch] != P_OFF) && (m_phase[ch] != P_FAIL);
            s[ch] = (m_phase[ch] == P_STBY);
            r[ch] = (m_phase[ch] == P_RUN) || (m_phase[ch] == P_STBY);
            f[ch] = (m_phase[ch] == P_FAIL);
        end
        return {15'd0, e, s, r, f, m_irq};
    endfunction

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        m_cyc++;
        if (reset) begin
            m_irq = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                m_phase[ch] = P_OFF;
                m_stay[ch]  = 0;
                m_age[ch]   = 0;
                m_edges[ch] = 0;
                for (int i = 0; i < 4; i++) m_log[ch][i] = 1'b0;
            end
        end else begin
            m_irq = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                int prev;
                bit e;
                // a rise sampled at cycle c-2 is counted at cycle c
                e = m_log[ch][(m_cyc - 2) % 4] && !m_log[ch][(m_cyc - 3) % 4];
                m_log[ch][m_cyc % 4] = osc_dout[ch];
                prev = m_phase[ch];
                if (!ch_req[ch]) begin
                    m_phase[ch] = P_OFF;
                end else begin
                    case (m_phase[ch])
                        P_OFF: begin
                            m_phase[ch] = P_START;
                            m_stay[ch]  = int'(startup_cycles[ch*CNT_W +: CNT_W]) + 1;
                        end
                        P_START: begin
                            m_stay[ch]--;
                            if (m_stay[ch] == 0) begin
                                m_phase[ch] = P_CHECK;
                                m_age[ch]   = 0;
                                m_edges[ch] = 0;
                            end
                        end
                        P_CHECK, P_RUN: begin
                            m_age[ch]++;
                            m_edges[ch] += int'(e);
                            if (m_age[ch] == WIN_LEN) begin
                                if (m_edges[ch] < MIN_EDGES) m_phase[ch] = P_FAIL;
                                else if (m_phase[ch] == P_RUN && ch_standby_req[ch]) m_phase[ch] = P_STBY;
                                else m_phase[ch] = P_RUN;
                                m_age[ch]   = 0;
                                m_edges[ch] = 0;
                            end else if (m_phase[ch] == P_RUN && ch_standby_req[ch]) begin
                                m_phase[ch] = P_STBY;
                                m_age[ch]   = 0;
                                m_edges[ch] = 0;
                            end
                        end
                        P_STBY: begin
                            if (!ch_standby_req[ch]) begin
                                m_phase[ch] = P_CHECK;
                                m_age[ch]   = 0;
                                m_edges[ch] = 0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (m_phase[ch] == P_FAIL && prev != P_FAIL) m_irq = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        model_step();
        check_val("outs", dut_outs(), model_outs());
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        ch_req         = '0;
        ch_standby_req = '0;
        osc_dout       = '0;
        step();
        reset = 1'b0;
    endtask

    // ch0 from su=0: CHECK window covers cycles 3..258; pulse k is counted at k+2.
    task automatic run_edges(input int last_pulse, input string tag, input logic [31:0] exp_bits);
        do_reset();
        startup_cycles = '0;
        ch_req         = 4'b0001;
        for (int k = 1; k <= 258; k++) begin
            osc_dout[0] = (k == 50) || (k == 60) || (k == 70) || (k == last_pulse);
            step();
        end
        check_val(tag, {30'd0, ch_ready[0], ch_fail[0]}, exp_bits);
        osc_dout[0] = 1'b0;
    endtask

    function automatic int pick_period();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 0;
        if (r < 7) return $urandom_range(2, 12);
        return $urandom_range(56, 100);
    endfunction

    initial begin
        int irq_cnt, rdy_at, fail_at;
        startup_cycles = '0;

        // reset state
        reset = 1'b1; ch_req = '0; ch_standby_req = '0; osc_dout = '0;
        step(); step();
        check_val("reset_outs", dut_outs(), 32'd0);
        reset = 1'b0;

        // ch0 alive (period 8, su 10), ch1 dead (su 5)
        startup_cycles[0 +: CNT_W]     = 16'd10;
        startup_cycles[CNT_W +: CNT_W] = 16'd5;
        ch_req = 4'b0011;
        irq_cnt = 0; rdy_at = 0; fail_at = 0;
        for (int k = 1; k <= 300; k++) begin
            osc_dout[0] = ((k % 8) < 4);
            step();
            if (k == 1) check_val("ena_next_clk", {28'd0, osc_ena}, 32'h3);
            if (fail_irq) irq_cnt++;
            if (ch_ready[0] && rdy_at == 0) rdy_at = k;
            if (ch_fail[1] && fail_at == 0) fail_at = k;
        end
        check_val("ready0_latency", rdy_at, 32'd268);
        check_val("fail1_latency", fail_at, 32'd263);
        check_val("irq_pulses_single", irq_cnt, 32'd1);
        check_val("ena1_after_fail", {31'd0, osc_ena[1]}, 32'd0);
        ch_req[1] = 1'b0;
        step();
        check_val("fail1_cleared", {31'd0, ch_fail[1]}, 32'd0);

        // ch0 in RUN: stop the oscillator, fail within two windows
        osc_dout[0] = 1'b0;
        fail_at = 0;
        for (int k = 1; k <= 600; k++) begin
            step();
            if (ch_fail[0] && fail_at == 0) fail_at = k;
        end
        check_val("stop_fail_bound", {31'd0, (fail_at > 0) && (fail_at <= 512)}, 32'd1);

        // standby with stopped oscillator, then release -> re-check fails
        do_reset();
        startup_cycles[0 +: CNT_W] = 16'd2;
        ch_req = 4'b0001;
        for (int k = 1; k <= 300; k++) begin
            osc_dout[0] = ((k % 6) < 3);
            step();
        end
        ch_standby_req[0] = 1'b1;
        osc_dout[0] = 1'b0;
        for (int k = 1; k <= 600; k++) step();
        check_val("standby_hold", {29'd0, osc_standby[0], ch_ready[0], ch_fail[0]}, 32'h6);
        ch_standby_req[0] = 1'b0;
        step();
        check_val("standby_release_ready", {31'd0, ch_ready[0]}, 32'd0);
        fail_at = 1;
        for (int k = 2; k <= 300; k++) begin
            step();
            if (ch_fail[0] && fail_at == 1) fail_at = k;
        end
        check_val("recheck_fail_latency", fail_at, 32'd257);

        // exactly four edges incl. one on the window-end cycle, vs three
        run_edges(256, "edge_at_window_end", 32'h2);
        run_edges(257, "three_edges_fail", 32'h1);

        // reset mid-CHECK
        do_reset();
        ch_req = 4'b0001;
        for (int k = 1; k <= 20; k++) step();
        reset = 1'b1;
        step();
        check_val("reset_mid_check", dut_outs(), 32'd0);
        reset = 1'b0;

        // simultaneous failure of ch1 and ch2
        do_reset();
        startup_cycles[CNT_W +: CNT_W]   = 16'd3;
        startup_cycles[2*CNT_W +: CNT_W] = 16'd3;
        ch_req = 4'b0110;
        irq_cnt = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (fail_irq) irq_cnt++;
        end
        check_val("dual_fail", {28'd0, ch_fail}, 32'h6);
        check_val("dual_irq_pulses", irq_cnt, 32'd1);

        // randomized traffic
        do_reset();
        ch_req = 4'b1111;
        for (int ch = 0; ch < NCH; ch++) begin
            per[ch] = 2 + ch;
            pc[ch]  = 0;
            startup_cycles[ch*CNT_W +: CNT_W] = 16'($urandom_range(0, 20));
        end
        for (int cyc = 0; cyc < 14000; cyc++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 499) == 0) ch_req[ch] = ~ch_req[ch];
                if ($urandom_range(0, 399) == 0) ch_standby_req[ch] = ~ch_standby_req[ch];
                if ($urandom_range(0, 599) == 0) begin
                    per[ch] = pick_period();
                    pc[ch]  = 0;
                end
                if ($urandom_range(0, 49) == 0)
                    startup_cycles[ch*CNT_W +: CNT_W] = 16'($urandom_range(0, 20));
                osc_dout[ch] = (per[ch] != 0) && (pc[ch] < per[ch] / 2);
                pc[ch] = (per[ch] == 0) ? 0 : (pc[ch] + 1) % per[ch];
            end
            reset = ($urandom_range(0, 2999) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
